// File: rtl/watch_pkg.sv
// Shared definitions for the watch: button index map, clock rate and the
// per-button conditioner state encoding.
package watch_pkg;

  localparam int BTN_RESET = 0;
  localparam int BTN_MODE  = 1;
  localparam int BTN_EDIT  = 2;
  localparam int BTN_INC   = 3;
  localparam int BTN_START = 4;

  localparam int CLK_HZ = 100_000_000;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold counter and,
// with BTN_AUTOREPEAT_EN defined, an auto-repeat counter.
module btn_debounce
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_hold,
  output logic btn_release
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);

  logic s1_q, s2_q;
  btn_state_t state_q, state_d;
  logic [DW-1:0] db_q, db_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic level_q, level_d, press_q, press_d, hold_q, hold_d, rel_q, rel_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  always_comb begin
    state_d    = state_q;
    db_d       = db_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    hold_d     = 1'b0;
    rel_d      = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rep_d      = rep_q;
`endif
    case (state_q)
      IDLE: if (s2_q) begin
        state_d = PRESS_WAIT;
        db_d    = DB_ONE;
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          level_d = 1'b1;
          db_d    = '0;
        end else db_d = db_q + DB_ONE;
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          db_d    = DB_ONE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          hold_d     = 1'b1;
          hold_cnt_d = HOLD_SAT;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
`ifdef BTN_AUTOREPEAT_EN
        // Repeat only runs once the hold has fired (counter saturated).
        else if (rep_q == REP_LAST) begin
          press_d = 1'b1;
          rep_d   = '0;
        end else rep_d = rep_q + RW'(1);
`endif
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = PRESSED;
          db_d    = '0;
`ifdef BTN_AUTOREPEAT_EN
          rep_d   = '0;
`endif
        end else if (db_q == DB_LAST) begin
          state_d    = IDLE;
          rel_d      = 1'b1;
          level_d    = 1'b0;
          db_d       = '0;
          hold_cnt_d = '0;
`ifdef BTN_AUTOREPEAT_EN
          rep_d      = '0;
`endif
        end else db_d = db_q + DB_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= IDLE;
      db_q       <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      hold_q     <= 1'b0;
      rel_q      <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      s1_q       <= btn_raw;
      s2_q       <= s1_q;
      state_q    <= state_d;
      db_q       <= db_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      hold_q     <= hold_d;
      rel_q      <= rel_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_hold    = hold_q;
  assign btn_release = rel_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button input stage: NUM_BTN independent debounce channels producing
// level, press, hold and release. Auto-repeat is enabled by BTN_AUTOREPEAT_EN.
module btn_conditioner
  import watch_pkg::*;
#(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_hold,
  output logic [NUM_BTN-1:0] btn_release
);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("btn_conditioner: inconsistent timing parameters");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_hold   (btn_hold[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected pulses (cycle, channel, kind)
// are queued as stimulus is applied and matched against every observed pulse.
module tb_btn_conditioner;

  localparam int NB = 5;
  localparam int D  = 4;
  localparam int H  = 20;
  localparam int R  = 5;

  logic clk = 1'b0;
  logic reset;
  logic [NB-1:0] btn_raw, btn_level, btn_press, btn_hold, btn_release;

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_hold(btn_hold), .btn_release(btn_release)
  );

  typedef struct {int cyc; int ch; int kind;} ev_t;  // kind: 0 press, 1 hold, 2 release
  ev_t exp_q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_ev(int c, int ch, int k);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = k;
    exp_q.push_back(e);
  endfunction

  task automatic chk(string tag, logic [NB-1:0] obs, logic [NB-1:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Every observed pulse must be the next queued expectation.
  always @(negedge clk) begin
    for (int ch = 0; ch < NB; ch++) begin
      logic [2:0] p;
      p = {btn_release[ch], btn_hold[ch], btn_press[ch]};
      if (p != 3'b000) begin
        n_chk++;
        assert ($countones(p) == 1) else begin
          n_fail++;
          $error("FAIL pulse_overlap: ch%0d observed %b expected one-hot", ch, p);
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (p[k]) begin
          n_chk++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_pulse: observed kind %0d ch%0d cyc %0d expected none", k, ch, cyc);
          end
          if (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_chk++;
            assert (e.cyc == cyc && e.ch == ch && e.kind == k) else begin
              n_fail++;
              $error("FAIL pulse: observed cyc %0d ch%0d kind %0d expected cyc %0d ch%0d kind %0d",
                     cyc, ch, k, e.cyc, e.ch, e.kind);
            end
          end
          if (k != 1) begin
            n_chk++;
            assert (btn_level[ch] === (k == 0)) else begin
              n_fail++;
              $error("FAIL level_at_pulse: ch%0d kind %0d observed %b expected %b",
                     ch, k, btn_level[ch], (k == 0));
            end
          end
        end
      end
    end
  end

  initial begin
    int n, m;
    reset   = 1'b1;
    btn_raw = '0;
    repeat (3) @(negedge clk);
    chk("reset_level",   btn_level,   '0);
    chk("reset_press",   btn_press,   '0);
    chk("reset_hold",    btn_hold,    '0);
    chk("reset_release", btn_release, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Clean press and release on channel 1
    n = cyc; btn_raw[1] = 1'b1; expect_ev(n + 6, 1, 0);
    repeat (10) @(negedge clk);
    chk("clean_level_hi", btn_level, 5'b00010);
    m = cyc; btn_raw[1] = 1'b0; expect_ev(m + 6, 1, 2);
    repeat (10) @(negedge clk);
    chk("clean_level_lo", btn_level, '0);

    // Bounce on channel 3: no pulses
    btn_raw[3] = 1'b1; @(negedge clk);
    btn_raw[3] = 1'b0; @(negedge clk);
    btn_raw[3] = 1'b1; @(negedge clk);
    btn_raw[3] = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_level", btn_level, '0);

    // Long hold on channel 4
    n = cyc; btn_raw[4] = 1'b1;
    expect_ev(n + 6, 4, 0);
    expect_ev(n + 6 + H, 4, 1);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(n + 6 + H + R, 4, 0);
    expect_ev(n + 6 + H + 2 * R, 4, 0);
`endif
    repeat (36) @(negedge clk);
    chk("hold_level", btn_level, 5'b10000);
    m = cyc; btn_raw[4] = 1'b0; expect_ev(m + 6, 4, 2);
    repeat (12) @(negedge clk);

    // Release glitch on channel 1: FSM spends 3 cycles out of PRESSED, delaying hold by 3
    n = cyc; btn_raw[1] = 1'b1;
    expect_ev(n + 6, 1, 0);
    expect_ev(n + 6 + H + 3, 1, 1);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(n + 6 + H + 3 + R, 1, 0);
    expect_ev(n + 6 + H + 3 + 2 * R, 1, 0);
`endif
    repeat (10) @(negedge clk);
    btn_raw[1] = 1'b0;
    repeat (2) @(negedge clk);
    btn_raw[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_level", btn_level, 5'b00010);
    repeat (26) @(negedge clk);
    m = cyc; btn_raw[1] = 1'b0; expect_ev(m + 6, 1, 2);
    repeat (12) @(negedge clk);

    // Simultaneous press on channels 0 and 2
    n = cyc; btn_raw[0] = 1'b1; btn_raw[2] = 1'b1;
    expect_ev(n + 6, 0, 0); expect_ev(n + 6, 2, 0);
    repeat (10) @(negedge clk);
    chk("simul_level", btn_level, 5'b00101);
    m = cyc; btn_raw[0] = 1'b0; btn_raw[2] = 1'b0;
    expect_ev(m + 6, 0, 2); expect_ev(m + 6, 2, 2);
    repeat (12) @(negedge clk);

    // Reset while channel 1 is in PRESSED, then re-qualification
    n = cyc; btn_raw[1] = 1'b1; expect_ev(n + 6, 1, 0);
    repeat (10) @(negedge clk);
    m = cyc; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_level",   btn_level,   '0);
    chk("rst_mid_press",   btn_press,   '0);
    chk("rst_mid_hold",    btn_hold,    '0);
    chk("rst_mid_release", btn_release, '0);
    expect_ev(m + 7, 1, 0);
    repeat (10) @(negedge clk);
    chk("rst_requal_level", btn_level, 5'b00010);
    n = cyc; btn_raw[1] = 1'b0; expect_ev(n + 6, 1, 2);
    repeat (15) @(negedge clk);

    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL missing_pulses: observed %0d still queued expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
